// File: rtl/ex_div_pkg.sv
// Shared encodings for the execute-stage divider: RV32M op selector and FSM states.
package ex_div_pkg;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_CALC = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

    function automatic logic div_is_signed(input div_op_e op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

    function automatic logic div_is_rem(input div_op_e op);
        return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    endfunction

endpackage

// File: rtl/ex_div.sv
// Iterative RV32M restoring divider: one quotient bit per cycle, divide-by-zero
// and signed overflow resolved on the launch edge.
module ex_div
    import ex_div_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic [4:0]      waddr_i,
    input  logic            flush_i,
    output logic            stall_req_o,
    output logic            ready_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      waddr_o
);

    div_state_e      state_q, state_d;
    div_op_e         op_q;
    logic [4:0]      waddr_q;
    logic            neg_quo_q, neg_rem_q;
    logic [XLEN-1:0] dvd_q, dvs_q, rem_q, quo_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0] result_q;
    logic [4:0]      waddr_out_q;

    div_op_e         op_in;
    logic            in_signed, in_rem;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            div_zero, overflow, special;
    logic [XLEN-1:0] special_res;
    logic            launch;

    logic [XLEN-1:0] rem_shift, rem_next, quo_next;
    logic            sub_ok, last_iter;
    logic [XLEN-1:0] fin_quo, fin_rem, fin_res;

    // Launch-side decode: magnitudes and special cases from the raw operands
    always_comb begin
        op_in       = div_op_e'(op_i);
        in_signed   = div_is_signed(op_in);
        in_rem      = div_is_rem(op_in);
        a_neg       = in_signed & dividend_i[XLEN-1];
        b_neg       = in_signed & divisor_i[XLEN-1];
        abs_a       = a_neg ? ('0 - dividend_i) : dividend_i;
        abs_b       = b_neg ? ('0 - divisor_i) : divisor_i;
        div_zero    = (divisor_i == '0);
        overflow    = in_signed & (dividend_i == {1'b1, {(XLEN-1){1'b0}}}) & (divisor_i == '1);
        special     = div_zero | overflow;
        special_res = '0;
        if (div_zero) begin
            special_res = in_rem ? dividend_i : '1;
        end else if (overflow) begin
            special_res = in_rem ? '0 : dividend_i;
        end
        launch = (state_q == DIV_IDLE) & start_i & ~flush_i;
    end

    // One restoring step; the partial remainder never exceeds XLEN-1 significant
    // bits before the shift, so dropping rem_q's MSB loses nothing.
    always_comb begin
        rem_shift = {rem_q[XLEN-2:0], dvd_q[XLEN-1]};
        sub_ok    = (rem_shift >= dvs_q);
        rem_next  = sub_ok ? (rem_shift - dvs_q) : rem_shift;
        quo_next  = {quo_q[XLEN-2:0], sub_ok};
        last_iter = (cnt_q == CNT_W'(XLEN - 1));
        fin_quo   = neg_quo_q ? ('0 - quo_next) : quo_next;
        fin_rem   = neg_rem_q ? ('0 - rem_next) : rem_next;
        fin_res   = div_is_rem(op_q) ? fin_rem : fin_quo;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DIV_IDLE: if (start_i) state_d = special ? DIV_DONE : DIV_CALC;
            DIV_CALC: if (last_iter) state_d = DIV_DONE;
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
        if (flush_i) begin
            state_d = DIV_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DIV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= DIV_OP_DIV;
            waddr_q     <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            waddr_out_q <= '0;
        end else if (launch) begin
            op_q      <= op_in;
            waddr_q   <= waddr_i;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            dvd_q     <= abs_a;
            dvs_q     <= abs_b;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            if (special) begin
                result_q    <= special_res;
                waddr_out_q <= waddr_i;
            end
        end else if ((state_q == DIV_CALC) && !flush_i) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            dvd_q <= {dvd_q[XLEN-2:0], 1'b0};
            cnt_q <= cnt_q + 1'b1;
            if (last_iter) begin
                result_q    <= fin_res;
                waddr_out_q <= waddr_q;
            end
        end
    end

    // A flushed cycle never requests a hold, even mid-calculation
    assign stall_req_o = ((state_q == DIV_CALC) | launch) & ~flush_i;
    assign ready_o     = (state_q == DIV_DONE);
    assign result_o    = result_q;
    assign waddr_o     = waddr_out_q;

endmodule

// File: tb/tb_ex_div.sv
// Directed and randomized checks of ex_div against an arithmetic RV32M reference.
module tb_ex_div;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic [4:0]  waddr_i;
    logic        flush_i;
    logic        stall_req_o;
    logic        ready_o;
    logic [31:0] result_o;
    logic [4:0]  waddr_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_res;
    logic [4:0]  last_waddr;

    always #5 clk = ~clk;

    ex_div #(.XLEN(32), .CNT_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .op_i       (op_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .waddr_i    (waddr_i),
        .flush_i    (flush_i),
        .stall_req_o(stall_req_o),
        .ready_o    (ready_o),
        .result_o   (result_o),
        .waddr_o    (waddr_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        case (op)
            2'b00: return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa / sb);
            2'b01: return a / b;
            2'b10: return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wa, input string tag);
        logic [31:0] exp_res;
        int exp_lat;
        int lat;
        exp_res = ref_div(op, a, b);
        exp_lat = is_special(op, a, b) ? 0 : 32;
        @(negedge clk);
        start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; waddr_i = wa;
        #1 chk({tag, ".stall_launch"}, 32'(stall_req_o), 32'd1);
        @(posedge clk);
        #1 start_i = 1'b0;
        dividend_i = $urandom; divisor_i = $urandom;
        lat = 0;
        while (!ready_o && lat < 40) begin
            if (stall_req_o !== 1'b1) chk({tag, ".stall_calc"}, 32'(stall_req_o), 32'd1);
            @(posedge clk);
            #1 lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".ready"}, 32'(ready_o), 32'd1);
        chk({tag, ".result"}, result_o, exp_res);
        chk({tag, ".waddr"}, 32'(waddr_o), 32'(wa));
        chk({tag, ".stall_done"}, 32'(stall_req_o), 32'd0);
        @(posedge clk);
        #1 chk({tag, ".ready_drop"}, 32'(ready_o), 32'd0);
        chk({tag, ".hold"}, result_o, exp_res);
        last_res = exp_res;
        last_waddr = wa;
    endtask

    initial begin
        int rdy_seen;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0;
        op_i = 2'b00; dividend_i = '0; divisor_i = '0; waddr_i = '0;
        #12;
        chk("rst.ready", 32'(ready_o), 32'd0);
        chk("rst.stall", 32'(stall_req_o), 32'd0);
        chk("rst.result", result_o, 32'd0);
        chk("rst.waddr", 32'(waddr_o), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        do_op(2'b01, 32'd100, 32'd7, 5'd3, "divu_100_7");
        do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd4, "div_m7_2");
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd5, "rem_m7_2");
        do_op(2'b11, 32'hFFFF_FFF9, 32'd2, 5'd6, "remu_fff9_2");
        do_op(2'b01, 32'd5, 32'd0, 5'd7, "divu_5_0");
        do_op(2'b11, 32'd5, 32'd0, 5'd8, "remu_5_0");
        do_op(2'b00, 32'd5, 32'd0, 5'd9, "div_5_0");
        do_op(2'b10, 32'hFFFF_FFFB, 32'd0, 5'd10, "rem_m5_0");
        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, "div_ovf");
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, "rem_ovf");
        do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, "divu_big");
        do_op(2'b10, 32'd7, 32'hFFFF_FFFE, 5'd14, "rem_7_m2");
        do_op(2'b00, 32'hFFFF_FFFF, 32'h8000_0001, 5'd15, "div_edge");

        // Flush at iteration 10 of DIVU 1000/3
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b01; dividend_i = 32'd1000; divisor_i = 32'd3; waddr_i = 5'd20;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush_i = 1'b1;
        #1 chk("flush.stall_same_cycle", 32'(stall_req_o), 32'd0);
        @(posedge clk);
        #1 flush_i = 1'b0;
        chk("flush.ready", 32'(ready_o), 32'd0);
        chk("flush.stall_idle", 32'(stall_req_o), 32'd0);
        rdy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 if (ready_o) rdy_seen++;
        end
        chk("flush.no_ready", 32'(rdy_seen), 32'd0);
        chk("flush.result_kept", result_o, last_res);
        chk("flush.waddr_kept", 32'(waddr_o), 32'(last_waddr));
        do_op(2'b01, 32'd9, 32'd3, 5'd21, "divu_9_3");

        // Reset pulse at iteration 20
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b00; dividend_i = 32'd123456; divisor_i = 32'd77; waddr_i = 5'd22;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (19) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("arst.result", result_o, 32'd0);
        chk("arst.waddr", 32'(waddr_o), 32'd0);
        chk("arst.ready", 32'(ready_o), 32'd0);
        chk("arst.stall", 32'(stall_req_o), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        rdy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 if (ready_o) rdy_seen++;
        end
        chk("arst.no_ready", 32'(rdy_seen), 32'd0);

        // start_i together with flush_i in IDLE
        @(negedge clk);
        start_i = 1'b1; flush_i = 1'b1; op_i = 2'b01; dividend_i = 32'd50; divisor_i = 32'd5;
        #1 chk("sflush.stall", 32'(stall_req_o), 32'd0);
        @(posedge clk);
        #1 start_i = 1'b0; flush_i = 1'b0;
        chk("sflush.stall_after", 32'(stall_req_o), 32'd0);
        rdy_seen = 0;
        for (int i = 0; i < 36; i++) begin
            @(posedge clk);
            #1 if (ready_o || stall_req_o) rdy_seen++;
        end
        chk("sflush.idle", 32'(rdy_seen), 32'd0);
        chk("sflush.result", result_o, 32'd0);

        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 4))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = -32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            do_op(rop, ra, rb, 5'($urandom), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
